// File: rtl/updown_counter_pkg.sv
// Shared constants for the parametrised up/down counter: direction and
// boundary-mode encodings plus the default operand widths.
package updown_counter_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_STEP_W = 4;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/updown_counter_step.sv
// Combinational next-value and boundary detection for the up/down counter.
// All arithmetic is done one bit wider than the count so nothing wraps silently.
module updown_counter_step
   import updown_counter_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STEP_W = DEF_STEP_W
) (
   input  logic [WIDTH-1:0]  count,
   input  logic              mode,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  limit,
   input  logic              sat,
   output logic [WIDTH-1:0]  next_count,
   output logic              hit_up,
   output logic              hit_dn,
   output logic              bad_step
);

   logic [WIDTH:0] c_x;
   logic [WIDTH:0] s_x;
   logic [WIDTH:0] l_x;
   logic [WIDTH:0] lp1_x;
   logic [WIDTH:0] sum_x;
   logic [WIDTH:0] res_x;

   assign c_x   = {1'b0, count};
   assign s_x   = {{(WIDTH+1-STEP_W){1'b0}}, step};
   assign l_x   = {1'b0, limit};
   assign lp1_x = l_x + 1'b1;
   assign sum_x = c_x + s_x;

   always_comb begin
      res_x    = c_x;
      hit_up   = 1'b0;
      hit_dn   = 1'b0;
      bad_step = 1'b0;
      if (step == '0) begin
         res_x = c_x;
      end else if (c_x > l_x) begin
         // limit was lowered under a running count: pull back silently
         res_x = l_x;
      end else if (sat == MODE_WRAP && s_x > lp1_x) begin
         bad_step = 1'b1;
      end else if (mode == DIR_UP) begin
         if (sum_x > l_x) begin
            hit_up = 1'b1;
            res_x  = (sat == MODE_SAT) ? l_x : (sum_x - lp1_x);
         end else begin
            res_x = sum_x;
         end
      end else begin
         if (c_x < s_x) begin
            hit_dn = 1'b1;
            res_x  = (sat == MODE_SAT) ? '0 : (c_x + lp1_x - s_x);
         end else begin
            res_x = c_x - s_x;
         end
      end
   end

   assign next_count = res_x[WIDTH-1:0];

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, clear, saturate/wrap and sticky flags.
// All outputs are registered; one clock from sampled inputs.
module updown_counter_param
   import updown_counter_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STEP_W = DEF_STEP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              mode,
   input  logic              clr,
   input  logic              ld,
   input  logic [WIDTH-1:0]  d_in,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  limit,
   input  logic              sat,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              ovf,
   output logic              unf,
   output logic              err
);

   logic [WIDTH-1:0] next_count;
   logic             hit_up;
   logic             hit_dn;
   logic             bad_step;

   updown_counter_step #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_step (
      .count      (count),
      .mode       (mode),
      .step       (step),
      .limit      (limit),
      .sat        (sat),
      .next_count (next_count),
      .hit_up     (hit_up),
      .hit_dn     (hit_dn),
      .bad_step   (bad_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
         err   <= 1'b0;
      end else if (ld) begin
         count <= (d_in > limit) ? limit : d_in;
         tc    <= 1'b0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
         err   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
         err   <= 1'b0;
      end else if (en) begin
         count <= next_count;
         tc    <= hit_up | hit_dn;
         ovf   <= ovf | hit_up;
         unf   <= unf | hit_dn;
         err   <= err | bad_step;
      end else begin
         tc    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: directed vector table, reset corner cases,
// then a randomized phase against an integer reference model.
module tb_updown_counter_param;

   logic       clk;
   logic       rst_n;
   logic       en, mode, clr, ld, sat;
   logic [7:0] d_in, limit;
   logic [3:0] step;
   logic [7:0] count;
   logic       tc, ovf, unf, err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       ld, clr, en, mode, sat;
      logic [7:0] d_in;
      logic [3:0] step;
      logic [7:0] limit;
      logic [7:0] e_count;
      logic       e_tc, e_ovf, e_unf, e_err;
   } vec_t;

   typedef struct packed {
      logic [7:0] count;
      logic       tc, ovf, unf, err;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   int m_count, m_tc, m_ovf, m_unf, m_err;

   updown_counter_param #(.WIDTH(8), .STEP_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .clr   (clr),
      .ld    (ld),
      .d_in  (d_in),
      .step  (step),
      .limit (limit),
      .sat   (sat),
      .count (count),
      .tc    (tc),
      .ovf   (ovf),
      .unf   (unf),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic void add(input logic l, c, e, m, s, input logic [7:0] d,
                               input logic [3:0] st, input logic [7:0] lim,
                               input logic [7:0] ec, input logic et, eo, eu, ee);
      vec_t v;
      v.ld = l; v.clr = c; v.en = e; v.mode = m; v.sat = s;
      v.d_in = d; v.step = st; v.limit = lim;
      v.e_count = ec; v.e_tc = et; v.e_ovf = eo; v.e_unf = eu; v.e_err = ee;
      vecs.push_back(v);
   endfunction

   function automatic void push_exp(input logic [7:0] c, input logic t, o, u, e);
      exp_t x;
      x.count = c; x.tc = t; x.ovf = o; x.unf = u; x.err = e;
      sb.push_back(x);
   endfunction

   task automatic check_out(input string nm);
      exp_t x;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, got count=%0d", nm, count);
      end else begin
         x = sb.pop_front();
         if (count !== x.count || tc !== x.tc || ovf !== x.ovf ||
             unf !== x.unf || err !== x.err) begin
            errors++;
            $display("FAIL %s: got count=%0d tc=%b ovf=%b unf=%b err=%b, expected count=%0d tc=%b ovf=%b unf=%b err=%b",
                     nm, count, tc, ovf, unf, err, x.count, x.tc, x.ovf, x.unf, x.err);
         end
      end
   endtask

   task automatic drive(input logic l, c, e, m, s, input logic [7:0] d,
                        input logic [3:0] st, input logic [7:0] lim);
      ld = l; clr = c; en = e; mode = m; sat = s;
      d_in = d; step = st; limit = lim;
   endtask

   task automatic model_next();
      m_tc = 0;
      if (ld) begin
         m_count = (int'(d_in) < int'(limit)) ? int'(d_in) : int'(limit);
         m_ovf = 0; m_unf = 0; m_err = 0;
      end else if (clr) begin
         m_count = 0; m_ovf = 0; m_unf = 0; m_err = 0;
      end else if (en && step != 0) begin
         if (m_count > int'(limit)) begin
            m_count = int'(limit);
         end else if (!sat && int'(step) > int'(limit) + 1) begin
            m_err = 1;
         end else if (mode) begin
            if (m_count + int'(step) > int'(limit)) begin
               m_ovf = 1; m_tc = 1;
               m_count = sat ? int'(limit) : m_count + int'(step) - int'(limit) - 1;
            end else begin
               m_count = m_count + int'(step);
            end
         end else begin
            if (m_count < int'(step)) begin
               m_unf = 1; m_tc = 1;
               m_count = sat ? 0 : m_count + int'(limit) + 1 - int'(step);
            end else begin
               m_count = m_count - int'(step);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 8'h00, 4'd0, 8'h00);

      // ld clr en mode sat d_in step limit | count tc ovf unf err
      add(0, 1, 0, 0, 0, 8'h00, 4'd0, 8'd9, 8'd0, 0, 0, 0, 0);
      for (int i = 1; i <= 9; i++)
         add(0, 0, 1, 1, 0, 8'h00, 4'd1, 8'd9, 8'(i), 0, 0, 0, 0);
      add(0, 0, 1, 1, 0, 8'h00, 4'd1, 8'd9, 8'd0, 1, 1, 0, 0);
      add(0, 0, 1, 1, 0, 8'h00, 4'd1, 8'd9, 8'd1, 0, 1, 0, 0);
      add(0, 0, 1, 1, 0, 8'h00, 4'd1, 8'd9, 8'd2, 0, 1, 0, 0);
      // saturating down from a load
      add(1, 0, 0, 0, 1, 8'd10, 4'd7, 8'd200, 8'd10, 0, 0, 0, 0);
      add(0, 0, 1, 0, 1, 8'd0,  4'd7, 8'd200, 8'd3,  0, 0, 0, 0);
      add(0, 0, 1, 0, 1, 8'd0,  4'd7, 8'd200, 8'd0,  1, 0, 1, 0);
      add(0, 0, 1, 0, 1, 8'd0,  4'd7, 8'd200, 8'd0,  1, 0, 1, 0);
      add(0, 0, 1, 0, 1, 8'd0,  4'd7, 8'd200, 8'd0,  1, 0, 1, 0);
      add(0, 0, 0, 0, 1, 8'd0,  4'd7, 8'd200, 8'd0,  0, 0, 1, 0);
      // ld beats clr beats en; saturate up; clr clears flags
      add(1, 1, 1, 1, 1, 8'h55, 4'd1,  8'hFF, 8'h55, 0, 0, 0, 0);
      add(0, 0, 1, 1, 1, 8'h00, 4'd15, 8'h58, 8'h58, 1, 1, 0, 0);
      add(0, 1, 1, 1, 1, 8'h00, 4'd1,  8'h58, 8'h00, 0, 0, 0, 0);
      // illegal wrap step holds and flags err; ld clamps to limit
      add(1, 0, 0, 1, 0, 8'd3,   4'd9, 8'd5, 8'd3, 0, 0, 0, 0);
      add(0, 0, 1, 1, 0, 8'd0,   4'd9, 8'd5, 8'd3, 0, 0, 0, 1);
      add(0, 0, 1, 1, 0, 8'd0,   4'd9, 8'd5, 8'd3, 0, 0, 0, 1);
      add(1, 0, 0, 1, 0, 8'd250, 4'd9, 8'd5, 8'd5, 0, 0, 0, 0);
      // wrap down, wrap up with step = limit+1, zero step holds
      add(0, 0, 1, 0, 0, 8'd0, 4'd4, 8'd5, 8'd1, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 8'd0, 4'd4, 8'd5, 8'd3, 1, 0, 1, 0);
      add(0, 0, 1, 1, 0, 8'd0, 4'd6, 8'd5, 8'd3, 1, 1, 1, 0);
      add(0, 0, 1, 1, 0, 8'd0, 4'd0, 8'd5, 8'd3, 0, 1, 1, 0);
      // limit lowered under the count
      add(1, 0, 0, 1, 0, 8'd8, 4'd1, 8'd255, 8'd8, 0, 0, 0, 0);
      add(0, 0, 1, 1, 0, 8'd0, 4'd1, 8'd4,   8'd4, 0, 0, 0, 0);
      add(0, 0, 1, 1, 0, 8'd0, 4'd1, 8'd4,   8'd0, 1, 1, 0, 0);

      #3;
      push_exp(8'd0, 0, 0, 0, 0);
      check_out("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ld, vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].sat,
               vecs[i].d_in, vecs[i].step, vecs[i].limit);
         push_exp(vecs[i].e_count, vecs[i].e_tc, vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_err);
         @(posedge clk); #1;
         check_out($sformatf("vec%0d", i));
         @(negedge clk);
      end

      // asynchronous reset mid-count, then clean release
      drive(1, 0, 0, 1, 0, 8'h42, 4'd1, 8'hFF);
      push_exp(8'h42, 0, 0, 0, 0);
      @(posedge clk); #1;
      check_out("load_42");
      @(negedge clk);
      drive(0, 0, 1, 1, 0, 8'h00, 4'd1, 8'hFF);
      #2 rst_n = 1'b0;
      #1;
      push_exp(8'd0, 0, 0, 0, 0);
      check_out("async_reset");
      @(posedge clk); #1;
      push_exp(8'd0, 0, 0, 0, 0);
      check_out("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      push_exp(8'd1, 0, 0, 0, 0);
      @(posedge clk); #1;
      check_out("reset_release");
      @(negedge clk);

      m_count = 0; m_tc = 0; m_ovf = 0; m_unf = 0; m_err = 0;
      limit = 8'($urandom_range(0, 255));
      for (int i = 0; i < 400; i++) begin
         if (($urandom_range(0, 15)) == 0) limit = 8'($urandom_range(0, 255));
         ld   = (i != 0) && ($urandom_range(0, 19) == 0);
         clr  = (i == 0) || ($urandom_range(0, 24) == 0);
         en   = ($urandom_range(0, 3) != 0);
         mode = 1'($urandom_range(0, 1));
         sat  = 1'($urandom_range(0, 1));
         d_in = 8'($urandom_range(0, 255));
         step = 4'($urandom_range(0, 15));
         model_next();
         push_exp(8'(m_count), 1'(m_tc), 1'(m_ovf), 1'(m_unf), 1'(m_err));
         @(posedge clk); #1;
         check_out($sformatf("rand%0d", i));
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
